// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM state, debug view,
// frame geometry and the frame acceptance check.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BREAK_CODE      = 8'hF0;
    localparam int         FRAME_DATA_BITS = 8;

    typedef struct packed {
        ps2_state_e state;
        logic [2:0] bit_cnt;
        logic       clk_level;
        logic       data_level;
        logic       data_fall;
    } ps2_dbg_t;

    // Odd parity over data+parity and a high stop bit make a good frame.
    function automatic logic frame_ok(logic [7:0] data, logic parity, logic stop);
        return stop & (^{data, parity});
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Downstream side of the PS/2 receiver: decoded key stream, FIFO push and status.
// Valid/ready: key_valid is a single-cycle pulse and is never held off; full is
// the only back-pressure, wr_en = key_valid & ~full, and a pulse seen with full
// high is lost and recorded in the sticky overflow flag.
interface ps2_rx_if;
    logic       full;
    logic [7:0] key_code;
    logic       key_valid;
    logic       wr_en;
    logic       parity_err;
    logic       overflow;

    modport master (
        input  full,
        output key_code, key_valid, wr_en, parity_err, overflow
    );

    modport slave (
        output full,
        input  key_code, key_valid, wr_en, parity_err, overflow
    );
endinterface

// File: rtl/ps2_sync_filter.sv
// One PS/2 line: 2-flop synchronizer, FILTER_LEN-sample glitch filter and a
// registered falling-edge pulse. The filtered level resets to the idle-high state.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples disagreeing with the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q;
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filters both lines, deframes 11-bit frames and emits
// scan codes. Define PS2_BREAK_FILTER_EN to drop 8'hF0 and the byte after it.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       full,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       wr_en,
    output logic       parity_err,
    output logic       overflow,
    output ps2_dbg_t   dbg_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_level, clk_fall;
    logic data_level, data_fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .raw_i(ps2_clk), .level_o(clk_level), .fall_o(clk_fall)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .raw_i(ps2_data), .level_o(data_level), .fall_o(data_fall)
    );

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [7:0]    key_code_q;
    logic          key_valid_q;
    logic          parity_err_q;
    logic          overflow_q;
    logic [TW-1:0] to_cnt_q;
`ifdef PS2_BREAK_FILTER_EN
    logic          break_pend_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            to_cnt_q     <= '0;
`ifdef PS2_BREAK_FILTER_EN
            break_pend_q <= 1'b0;
`endif
        end else begin
            key_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (key_valid_q && full) overflow_q <= 1'b1;

            if (state_q == IDLE) begin
                to_cnt_q <= '0;
                if (clk_fall && !data_level) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                    shift_q   <= '0;
                end
            end else if (clk_fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q   <= {data_level, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= data_level;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (frame_ok(shift_q, parity_q, data_level)) begin
`ifdef PS2_BREAK_FILTER_EN
                            // The byte after a break prefix is the released key: drop both.
                            if (break_pend_q) begin
                                break_pend_q <= 1'b0;
                            end else if (shift_q == BREAK_CODE) begin
                                break_pend_q <= 1'b1;
                            end else begin
                                key_code_q  <= shift_q;
                                key_valid_q <= 1'b1;
                            end
`else
                            key_code_q  <= shift_q;
                            key_valid_q <= 1'b1;
`endif
                        end else begin
                            parity_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q  <= IDLE;
                to_cnt_q <= '0;
`ifdef PS2_BREAK_FILTER_EN
                break_pend_q <= 1'b0;
`endif
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign wr_en      = key_valid_q & ~full;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

    assign dbg_o.state      = state_q;
    assign dbg_o.bit_cnt    = bit_cnt_q;
    assign dbg_o.clk_level  = clk_level;
    assign dbg_o.data_level = data_level;
    assign dbg_o.data_fall  = data_fall;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames are bit-banged on ps2_clk/ps2_data and the
// decoded stream is compared against hand-computed scan codes.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FL = 4;
    localparam int TO = 200;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     ps2_clk = 1'b1;
    logic     ps2_data = 1'b1;
    ps2_dbg_t dbg;

    ps2_rx_if bus ();

    always #5 clk = ~clk;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .full(bus.full), .key_code(bus.key_code), .key_valid(bus.key_valid),
        .wr_en(bus.wr_en), .parity_err(bus.parity_err), .overflow(bus.overflow),
        .dbg_o(dbg)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Monitor: collect emitted codes and strobe counts away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.key_valid) obs_q.push_back(bus.key_code);
            if (bus.wr_en) wr_cnt++;
            if (bus.parity_err) perr_cnt++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        perr_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
        logic par;
        par = ~(^d) ^ par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop_bit);
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.full = 1'b0;
        wait_cyc(4);
        @(negedge clk);
        checks++; if (bus.key_code !== 8'h00) begin errors++; $display("FAIL reset_key_code got=%h exp=00", bus.key_code); end
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", bus.parity_err); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg.state); end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_single_frame();
        clear_mon();
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        else begin checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_code got=%h exp=%h", obs_q[0], exp_q[0]); end end
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL single_wr_en got=%0d exp=1", wr_cnt); end
        checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL single_parity_err got=%0d exp=0", perr_cnt); end
        checks++; if (bus.key_code !== 8'h1C) begin errors++; $display("FAIL single_hold got=%h exp=1c", bus.key_code); end
    endtask

    task automatic test_bad_parity();
        clear_mon();
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++; if (perr_cnt !== 1) begin errors++; $display("FAIL parity_err_pulses got=%0d exp=1", perr_cnt); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL parity_no_valid got=%0d exp=0", obs_q.size()); end
        checks++; if (bus.key_code !== 8'h1C) begin errors++; $display("FAIL parity_code_kept got=%h exp=1c", bus.key_code); end
    endtask

    task automatic test_bad_stop();
        clear_mon();
        send_frame(8'h32, 1'b0, 1'b0);
        checks++; if (perr_cnt !== 1) begin errors++; $display("FAIL stop_err_pulses got=%0d exp=1", perr_cnt); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL stop_no_valid got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_break_sequence();
        clear_mon();
`ifndef PS2_BREAK_FILTER_EN
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
`endif
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL break_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL break_code%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        bus.full = 1'b1;
        send_frame(8'h32, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL ovf_valid got=%0d exp=1", obs_q.size()); end
        else begin checks++; if (obs_q[0] !== 8'h32) begin errors++; $display("FAIL ovf_code got=%h exp=32", obs_q[0]); end end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL ovf_wr_en got=%0d exp=0", wr_cnt); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        bus.full = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL ovf_wr_after got=%0d exp=1", wr_cnt); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wait_cyc(TO + 10);
        @(negedge clk);
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL timeout_state got=%0d exp=0", dbg.state); end
        send_frame(8'h32, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", obs_q.size()); end
        else begin checks++; if (obs_q[0] !== 8'h32) begin errors++; $display("FAIL timeout_code got=%h exp=32", obs_q[0]); end end
        checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL timeout_parity_err got=%0d exp=0", perr_cnt); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        clear_mon();
        ps2_data = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(FL - 2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        @(negedge clk);
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL glitch_idle got=%0d exp=0", dbg.state); end
        ps2_data = 1'b1;
        wait_cyc(10);
        // Frame 0x1C with a short clock glitch after the third data bit.
        d = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 2) begin
                ps2_clk = 1'b0;
                wait_cyc(FL - 2);
                ps2_clk = 1'b1;
                wait_cyc(10);
            end
        end
        send_bit(~(^d));
        send_bit(1'b1);
        wait_cyc(30);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", obs_q.size()); end
        else begin checks++; if (obs_q[0] !== 8'h1C) begin errors++; $display("FAIL glitch_code got=%h exp=1c", obs_q[0]); end end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'hA5);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_code%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_frame_reset();
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        checks++; if (bus.key_code !== 8'h00) begin errors++; $display("FAIL rst_key_code got=%h exp=00", bus.key_code); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg.state); end
        rst = 1'b0;
        wait_cyc(10);
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", obs_q.size()); end
        else begin checks++; if (obs_q[0] !== 8'h1C) begin errors++; $display("FAIL rst_code got=%h exp=1c", obs_q[0]); end end
        checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL rst_parity_err got=%0d exp=0", perr_cnt); end
    endtask

    initial begin
        bus.full = 1'b0;
        test_reset();
        test_single_frame();
        test_bad_parity();
        test_bad_stop();
        test_break_sequence();
        test_overflow();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
Parameters:
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed before a filtered ps2_clk/ps2_data level changes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
Ports:
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 device clock.
REQ-006 SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 device data.
REQ-007 SHALL have port full, input, 1 bit: downstream FIFO full flag.
REQ-008 SHALL have port key_code, output, 8 bits: last accepted scan code.
REQ-009 SHALL have port key_valid, output, 1 bit: one-cycle pulse when key_code is updated.
REQ-010 SHALL have port wr_en, output, 1 bit: FIFO push strobe.
REQ-011 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a bad parity or stop bit.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, code lost because full was high.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer, then the FILTER_LEN glitch filter; filtered levels reset to 1.
REQ-014 SHALL define a sample event as filtered ps2_clk going 1->0.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP, reset state IDLE.
REQ-016 IDLE: on a sample event with data=0 (start bit), SHALL go to DATA with bit counter 0; a start bit of data=1 SHALL be ignored.
REQ-017 DATA: SHALL shift 8 bits LSB-first, one per sample event, then go to PARITY after the 8th bit.
REQ-018 PARITY: SHALL capture the parity bit on a sample event, then go to STOP.
REQ-019 STOP: on a sample event, SHALL accept the frame if the stop bit is 1 and data+parity has an odd number of ones, otherwise pulse parity_err; either way SHALL return to IDLE.
REQ-020 On accept, SHALL load key_code and assert key_valid for exactly one cycle, on the cycle after the stop-bit sample event.
REQ-021 SHALL drive wr_en = key_valid AND NOT full, combinationally.
REQ-022 If key_valid and full are both 1, SHALL set overflow to 1; it SHALL stay 1 until rst.
REQ-023 In any non-IDLE state, TIMEOUT_CYC cycles without a sample event SHALL force IDLE, with no key_valid and no parity_err; the counter SHALL restart on every sample event.
REQ-024 key_code SHALL hold its value between accepts.

Reset
REQ-025 rst=1 at any clk edge, including mid-frame, SHALL set: state IDLE, shift register 0, key_code 8'h00, key_valid 0, wr_en 0, parity_err 0, overflow 0, timeout counter 0.
REQ-026 A partially received frame SHALL be discarded by reset and never emitted.

Configuration
REQ-027 With macro PS2_BREAK_FILTER_EN defined, an accepted 8'hF0 byte and the next accepted byte SHALL both be dropped (no key_valid), so only make codes are emitted; a timeout or rst SHALL clear the pending-break flag.
REQ-028 Without PS2_BREAK_FILTER_EN, every accepted byte, including 8'hF0, SHALL be emitted.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state typedef, BREAK_CODE = 8'hF0, and FRAME_DATA_BITS = 8.
REQ-030 SHALL instantiate one sub-module, ps2_sync_filter (synchronizer, glitch filter, falling-edge detect), used once per PS/2 line.

Verification
REQ-031 Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> key_code=8'h1C, key_valid and wr_en high for 1 cycle, parity_err=0.
REQ-032 Same frame with parity 1 -> parity_err pulses once, key_valid stays 0, key_code unchanged.
REQ-033 Frames F0 then 1C -> with PS2_BREAK_FILTER_EN: no key_valid; without it: two pulses, 8'hF0 then 8'h1C.
REQ-034 full=1 during an accepted frame 0x32 -> key_valid=1, wr_en=0, overflow=1 and held until rst.
REQ-035 Frame aborted after 5 data bits, idle for TIMEOUT_CYC+10 cycles, then full frame 0x32 -> exactly one key_valid with key_code=8'h32; a ps2_clk glitch shorter than FILTER_LEN cycles -> no bit shifted.
REQ-036 rst asserted mid-frame after 4 bits, then full frame 0x1C -> all outputs at reset values, then exactly one key_valid with key_code=8'h1C.
